// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_TIMEOUT = 8;

  // Transaction sequencer states: accept/arbitrate, drive memory, wait, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin selector for two requesters.
// A lone requester always wins; on a tie the requester not granted last wins.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick the winner from the current request vector and the previous grant.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned (no latch).
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, one outstanding memory
// transaction at a time, bounded wait with timeout error reporting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rq0_valid,
  input  logic                  rq1_valid,
  input  logic                  rq0_wr_rd,
  input  logic                  rq1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [WIDTH-1:0]      rq0_wdata,
  input  logic [WIDTH-1:0]      rq1_wdata,
  output logic                  rq0_ready,
  output logic                  rq1_ready,
  output logic [WIDTH-1:0]      rq0_rdata,
  output logic [WIDTH-1:0]      rq1_rdata,
  output logic                  rq0_err,
  output logic                  rq1_err,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state, state_next;
  logic                  last_grant;
  logic                  winner;
  logic                  wr_rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      count_q;
  logic                  gnt_valid;
  logic                  gnt_idx;

  mem_arb_rr u_rr (
    .req        ({rq1_valid, rq0_valid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; mem_ready only matters while waiting.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mem_ready || count_q == CNT_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch winner fields, count wait cycles, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      winner     <= 1'b0;
      wr_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            winner  <= gnt_idx;
            wr_rd_q <= gnt_idx ? rq1_wr_rd : rq0_wr_rd;
            addr_q  <= gnt_idx ? rq1_addr  : rq0_addr;
            wdata_q <= gnt_idx ? rq1_wdata : rq0_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: count_q <= '0;
        WAIT: begin
          if (mem_ready) begin
            rdata_q <= wr_rd_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (count_q == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        RESP:    last_grant <= winner;
        default: ;
      endcase
    end
  end

  // Memory side: request strobe only in ISSUE, fields held from the latch.
  assign mem_valid = (state == ISSUE);
  assign mem_wr_rd = wr_rd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

  // Requester side: only the winner sees the response, and only in RESP.
  assign rq0_ready = (state == RESP) && !winner;
  assign rq1_ready = (state == RESP) &&  winner;
  assign rq0_rdata = rq0_ready ? rdata_q : '0;
  assign rq1_rdata = rq1_ready ? rdata_q : '0;
  assign rq0_err   = rq0_ready && err_q;
  assign rq1_err   = rq1_ready && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// responses; monitors compare requester responses and memory requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq0_valid, rq1_valid, rq0_wr_rd, rq1_wr_rd;
  logic [5:0]  rq0_addr, rq1_addr;
  logic [15:0] rq0_wdata, rq1_wdata;
  logic        rq0_ready, rq1_ready, rq0_err, rq1_err;
  logic [15:0] rq0_rdata, rq1_rdata;
  logic        mem_valid, mem_wr_rd, mem_ready, busy;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  typedef struct {
    logic        idx;
    logic [15:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
  } mreq_t;

  resp_t exp_q[$];
  mreq_t mem_q[$];
  int    checks   = 0;
  int    failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
    .rq0_wr_rd(rq0_wr_rd), .rq1_wr_rd(rq1_wr_rd),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
    .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
    .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
    .rq0_rdata(rq0_rdata), .rq1_rdata(rq1_rdata),
    .rq0_err(rq0_err), .rq1_err(rq1_err),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: answers one cycle after mem_valid unless resp_en is low.
  logic [15:0] mem [0:63];
  logic        resp_en = 1'b1;
  logic        pend;
  logic        hold_wr;
  logic [5:0]  hold_addr;
  logic [15:0] hold_wdata;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'(i)};
    mem_ready = 1'b0;
    mem_rdata = '0;
    pend      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (pend && resp_en) begin
        mem_ready = 1'b1;
        if (hold_wr) mem[hold_addr] = hold_wdata;
        else         mem_rdata = mem[hold_addr];
      end
      pend = mem_valid && !rst;
      if (mem_valid) begin
        hold_wr    = mem_wr_rd;
        hold_addr  = mem_addr;
        hold_wdata = mem_wdata;
      end
    end
  end

  // Monitors: requester responses against exp_q, memory side against mem_q.
  resp_t mon_e;
  mreq_t cur_m;
  logic  mon_w;
  logic  prev_ready     = 1'b0;
  logic  prev_mem_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rq0_ready || rq1_ready) begin
        check("ready_exclusive", 32'(rq0_ready & rq1_ready), 32'd0);
        check("ready_one_cycle", 32'(prev_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=rq0:%0b rq1:%0b required=none", rq0_ready, rq1_ready);
        end else begin
          mon_e = exp_q.pop_front();
          mon_w = rq1_ready;
          check("grant_idx", 32'(mon_w), 32'(mon_e.idx));
          check("rdata", 32'(mon_w ? rq1_rdata : rq0_rdata), 32'(mon_e.rdata));
          check("err", 32'(mon_w ? rq1_err : rq0_err), 32'(mon_e.err));
          check("loser_quiet", 32'(mon_w ? {rq0_err, rq0_rdata} : {rq1_err, rq1_rdata}), 32'd0);
        end
      end
      if (mem_valid) begin
        check("mem_valid_gap", 32'(prev_mem_valid), 32'd0);
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_valid actual=addr:%0h required=none", mem_addr);
        end else begin
          cur_m = mem_q.pop_front();
          check("mem_wr_rd", 32'(mem_wr_rd), 32'(cur_m.wr));
          check("mem_addr", 32'(mem_addr), 32'(cur_m.addr));
          check("mem_wdata", 32'(mem_wdata), 32'(cur_m.wdata));
        end
      end
      if (mem_ready) begin
        check("hold_addr", 32'(mem_addr), 32'(cur_m.addr));
        check("hold_wdata", 32'(mem_wdata), 32'(cur_m.wdata));
      end
    end
    prev_ready     = rq0_ready | rq1_ready;
    prev_mem_valid = mem_valid;
  end

  task automatic push_exp(input logic idx, input logic wr, input logic [5:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata, input logic err);
    resp_t r;
    mreq_t m;
    r.idx = idx; r.rdata = rdata; r.err = err;
    m.wr = wr; m.addr = addr; m.wdata = wdata;
    exp_q.push_back(r);
    mem_q.push_back(m);
  endtask

  // One transaction from a lone requester; fields are scrambled after the
  // grant to show only latched values reach memory. Called at a negedge.
  task automatic do_req(input logic idx, input logic wr, input logic [5:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int   n;
    logic done;
    push_exp(idx, wr, addr, wdata, exp_rdata, exp_err);
    if (idx) begin rq1_valid = 1; rq1_wr_rd = wr; rq1_addr = addr; rq1_wdata = wdata; end
    else     begin rq0_valid = 1; rq0_wr_rd = wr; rq0_addr = addr; rq0_wdata = wdata; end
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (idx ? rq1_ready : rq0_ready) done = 1;
      if (n == 1) begin
        #1;
        if (idx) begin rq1_wr_rd = ~wr; rq1_addr = ~addr; rq1_wdata = ~wdata; end
        else     begin rq0_wr_rd = ~wr; rq0_addr = ~addr; rq0_wdata = ~wdata; end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=no_ready required=ready_within_40");
    end else begin
      check("latency", 32'(n), 32'(exp_lat));
    end
    rq0_valid = 0;
    rq1_valid = 0;
    @(negedge clk);
    check("ready_pulse_end", 32'(rq0_ready | rq1_ready), 32'd0);
  endtask

  // Both requesters held valid; grants must alternate starting with rq0.
  task automatic tie(input int count);
    int pulses;
    int n;
    for (int i = 0; i < count; i++) begin
      if (i % 2 == 0) push_exp(1'b0, 1'b0, 6'd1, 16'h1111, 16'h0101, 1'b0);
      else            push_exp(1'b1, 1'b0, 6'd2, 16'h2222, 16'h0202, 1'b0);
    end
    rq0_valid = 1; rq0_wr_rd = 0; rq0_addr = 6'd1; rq0_wdata = 16'h1111;
    rq1_valid = 1; rq1_wr_rd = 0; rq1_addr = 6'd2; rq1_wdata = 16'h2222;
    pulses = 0;
    n = 0;
    while (pulses < count && n < count * 4 + 10) begin
      @(negedge clk);
      n++;
      if (rq0_ready || rq1_ready) pulses++;
    end
    check("tie_pulses", 32'(pulses), 32'(count));
    check("tie_cycles", 32'(n), 32'(count * 4 - 1));
    rq0_valid = 0;
    rq1_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    rq0_valid = 0; rq1_valid = 0; rq0_wr_rd = 0; rq1_wr_rd = 0;
    rq0_addr = '0; rq1_addr = '0; rq0_wdata = '0; rq1_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_fields", 32'({mem_wr_rd, mem_addr, mem_wdata}), 32'd0);
    check("rst_ready", 32'({rq0_ready, rq1_ready, rq0_err, rq1_err}), 32'd0);
    check("rst_rdata", 32'({rq0_rdata, rq1_rdata}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 0;

    tie(4);

    do_req(1'b0, 1'b1, 6'd5, 16'hA5A5, 16'h0000, 1'b0, 3);
    do_req(1'b1, 1'b0, 6'd5, 16'h0000, 16'hA5A5, 1'b0, 3);

    resp_en = 0;
    do_req(1'b0, 1'b0, 6'd3, 16'h3333, 16'h0000, 1'b1, 10);
    check("timeout_idle", 32'(busy), 32'd0);

    mem_q.push_back('{wr: 1'b0, addr: 6'd4, wdata: 16'h4444});
    rq1_valid = 1; rq1_wr_rd = 0; rq1_addr = 6'd4; rq1_wdata = 16'h4444;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1;
    rq1_valid = 0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_ready", 32'(rq0_ready | rq1_ready), 32'd0);
    rst = 0;
    resp_en = 1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    tie(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, data width; DEPTH, default 64, memory words; ADDR_WIDTH, default $clog2(DEPTH), address width; TIMEOUT, default 8, max cycles waiting for mem_ready.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- rq0_valid, rq1_valid  in  1  request pending
- rq0_wr_rd, rq1_wr_rd  in  1  1=write, 0=read
- rq0_addr, rq1_addr  in  ADDR_WIDTH  word address
- rq0_wdata, rq1_wdata  in  WIDTH  write data
- rq0_ready, rq1_ready  out  1  one-cycle completion pulse
- rq0_rdata, rq1_rdata  out  WIDTH  read data, valid with readyN
- rq0_err, rq1_err  out  1  timeout flag, valid with readyN
- mem_valid  out  1  request to memory
- mem_wr_rd  out  1  direction to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wdata  out  WIDTH  write data to memory
- mem_ready  in  1  memory completion
- mem_rdata  in  WIDTH  memory read data
- busy  out  1  high in any state other than IDLE

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: if any rqN_valid, SHALL select a winner, latch its wr_rd/addr/wdata and winner index, go ISSUE; otherwise stay IDLE.
REQ-005 Arbitration SHALL be round-robin over 2 requesters: a lone requester wins; if both request, the one not granted last wins; last_grant resets to 1, so requester 0 wins the first tie.
REQ-006 ISSUE: SHALL drive mem_valid=1 with latched fields for exactly one cycle, then go WAIT.
REQ-007 WAIT: mem_valid=0; mem_wr_rd/addr/wdata SHALL hold latched values; on mem_ready=1, latch mem_rdata (reads) and go RESP.
REQ-008 WAIT: SHALL count cycles from 0; if count reaches TIMEOUT-1 without mem_ready, go RESP with error set and latched rdata forced to 0.
REQ-009 RESP: SHALL assert ready, rdata and err of the winner only, for exactly one cycle; update last_grant to winner; go IDLE.
REQ-010 For writes, rqN_rdata SHALL be 0 in RESP.
REQ-011 The non-winning requester's ready/err SHALL remain 0 and its rdata SHALL remain 0.
REQ-012 Latency with memory answering one cycle after mem_valid: request seen in IDLE at cycle 0 -> mem_valid cycle 1 -> mem_ready cycle 2 -> rqN_ready cycle 3 -> IDLE cycle 4; max throughput one transaction per 4 cycles.
REQ-013 Requesters SHALL hold valid and fields stable until their ready pulse; the arbiter SHALL use only latched fields after IDLE, so mid-transaction changes or valid drop do not affect the transaction in flight.
REQ-014 A requester still asserting valid in the IDLE cycle after its RESP SHALL be treated as a new request.
REQ-015 mem_ready seen outside WAIT SHALL be ignored.
REQ-016 mem_valid SHALL never be high in two consecutive cycles.

Reset
REQ-017 On rst=1 at a clock edge SHALL enter IDLE regardless of state, abandoning any transaction without a ready pulse.
REQ-018 Reset values SHALL be: all outputs 0, including mem_valid, mem_wr_rd, mem_addr, mem_wdata, rqN_ready, rqN_rdata, rqN_err and busy; last_grant=1; timeout counter=0.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP) and default WIDTH/DEPTH/TIMEOUT constants.
REQ-020 Round-robin selection SHALL be a combinational sub-module mem_arb_rr with inputs req[1:0] and last_grant, and outputs gnt_valid and gnt_idx.
REQ-021 Timeout counter width SHALL be $clog2(TIMEOUT)+1.

Verification
REQ-022 Single write: rq0 writes addr=5, wdata=16'hA5A5; memory readies one cycle after mem_valid -> mem_valid cycle 1 with addr 5, data A5A5; rq0_ready cycle 3; rq0_err=0.
REQ-023 Read-back: rq1 reads addr=5 after REQ-022 -> rq1_ready pulse with rq1_rdata=16'hA5A5; rq0_ready stays 0.
REQ-024 Tie: both valid from reset, rq0 addr 1, rq1 addr 2, both held -> grant order rq0, rq1, rq0, rq1; mem_addr sequence 1, 2, 1, 2.
REQ-025 Timeout: mem_ready held 0 -> after 8 WAIT cycles, winner sees ready=1, err=1, rdata=0; FSM returns to IDLE.
REQ-026 Reset mid-WAIT: assert rst during WAIT -> next cycle busy=0, mem_valid=0, no ready pulse; the next tie is granted to rq0.
REQ-027 Protocol checks SHALL bind the memory handshake checker to the mem_* side in all scenarios with zero failures.
